alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 32-bit ripple ALU.
- Same op encoding on ALU_control/bonus_control, WIDTH-generic datapath.
- Registered outputs, iterative unsigned multiply as a multi-cycle op.
- Sits between the decode stage and writeback of the multi-cycle CPU; upstream and downstream stall via valid/ready.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_seq_mul.sv | 48 ++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, compare variants and FSM states shared by alu_seq and its multiplier
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [2:0] CMP_LT = 3'b000;
    localparam logic [2:0] CMP_GT = 3'b001;
    localparam logic [2:0] CMP_LE = 3'b010;
    localparam logic [2:0] CMP_GE = 3'b011;
    localparam logic [2:0] CMP_NE = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative LSB-first shift-add unsigned multiplier, one partial product per cycle
module alu_seq_mul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    // The product including this cycle's partial product, so the final value is ready on the last step
    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_o = acc_d;
    assign busy_o = cnt_q != '0;
    assign done_o = cnt_q == CNT_W'(1);

    // Load operands on start, then shift multiplicand left and multiplier right each step
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= CNT_W'(WIDTH);
        end else if (busy_o) begin
            mcand_q  <= mcand_q << 1;
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered outputs and multi-cycle MUL; ALU_SEQ_SHIFT_EN adds SLL/SRL/SRA
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    input  logic [2:0]       bonus_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               is_sub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic               add_ovf;
    logic               cmp_lt;
    logic               cmp_eq;
    logic               cmp_flag;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               alu_ovf;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
`ifdef ALU_SEQ_SHIFT_EN
    logic [CNT_W-2:0]   shamt;

    assign shamt = src2[CNT_W-2:0];
`endif

    // SLT shares the subtractor: A + ~B + 1
    assign is_sub   = (ALU_control == OP_SUB) || (ALU_control == OP_SLT);
    assign b_eff    = is_sub ? ~src2 : src2;
    assign sum      = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign add_ovf  = (src1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
    assign cmp_lt   = sum[WIDTH-1] ^ add_ovf;
    assign cmp_eq   = src1 == src2;
    assign cmp_flag = (bonus_control == CMP_GT) ? (!cmp_lt && !cmp_eq) :
                      (bonus_control == CMP_LE) ? (cmp_lt || cmp_eq) :
                      (bonus_control == CMP_GE) ? !cmp_lt :
                      (bonus_control == CMP_EQ) ? cmp_eq :
                      (bonus_control == CMP_NE) ? !cmp_eq : cmp_lt;

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign result    = result_q;
    assign zero      = result_q == '0;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

    alu_seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .a_i     (src1),
        .b_i     (src2),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // Single-cycle datapath; unknown opcodes fall through to zero result and flags
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (ALU_control)
            OP_AND: alu_res = src1 & src2;
            OP_OR:  alu_res = src1 | src2;
            OP_NOR: alu_res = ~(src1 | src2);
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, cmp_flag};
`ifdef ALU_SEQ_SHIFT_EN
            OP_SLL: alu_res = src1 << shamt;
            OP_SRL: alu_res = src1 >> shamt;
            OP_SRA: alu_res = $unsigned($signed(src1) >>> shamt);
`endif
            default: alu_res = '0;
        endcase
    end

    // Next state and output-register loads; outputs only change on accept or multiply completion
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && ALU_control == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end else if (in_valid) begin
                    result_d = alu_res;
                    cout_d   = alu_cout;
                    ovf_d    = alu_ovf;
                    state_d  = ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d = mul_prod[WIDTH-1:0];
                    cout_d   = |mul_prod[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    state_d  = ST_DONE;
                end else if (!mul_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a scoreboard queue checked by an independent output monitor
module tb_alu_seq;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [3:0]  alu_ctl = '0;
    logic [2:0]  bonus = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

`ifdef ALU_SEQ_SHIFT_EN
    localparam logic [31:0] SLL_EXP = 32'h0000_0010;
`else
    localparam logic [31:0] SLL_EXP = 32'h0000_0000;
`endif

    alu_seq dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .src1          (src1),
        .src2          (src2),
        .ALU_control   (alu_ctl),
        .bonus_control (bonus),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .cout          (cout),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [2:0] bc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic c, input logic v, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({nm, " accept timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        alu_ctl  = op;
        bonus    = bc;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        if (push) sb.push_back('{nm, res, res == 32'd0, c, v, lat, cyc});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: every rising out_valid must match the oldest outstanding expectation
    initial begin
        logic prev_ov = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) begin
                        chk("unexpected out_valid", 64'(result), 64'd0 - 64'd1);
                    end else begin
                        e = sb.pop_front();
                        chk({e.nm, " result"}, 64'(result), 64'(e.res));
                        chk({e.nm, " zero"}, 64'(zero), 64'(e.z));
                        chk({e.nm, " cout"}, 64'(cout), 64'(e.c));
                        chk({e.nm, " overflow"}, 64'(overflow), 64'(e.v));
                        chk({e.nm, " latency"}, 64'(cyc - e.acc), 64'(e.lat));
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        int bad;
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset zero", 64'(zero), 64'd1);
        chk("reset cout", 64'(cout), 64'd0);
        chk("reset overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("add ovf", 4'b0010, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1, 1'b1);
        issue("sub 5-5", 4'b0110, 3'b000, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1, 1'b1);
        issue("sub 0-1", 4'b0110, 3'b000, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b1);
        issue("slt lt", 4'b0111, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, 1'b1);
        issue("slt ge", 4'b0111, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        issue("slt eq", 4'b0111, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        issue("slt gt", 4'b0111, 3'b001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        issue("slt ne", 4'b0111, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, 1'b1);
        issue("slt 111 as lt", 4'b0111, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, 1'b1);
        issue("slt le equal", 4'b0111, 3'b010, 32'd7, 32'd7, 32'd1, 1'b0, 1'b0, 1, 1'b1);
        issue("and", 4'b0000, 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1, 1'b1);
        issue("nor", 4'b1100, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b1);
        issue("undef op", 4'b0100, 3'b000, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        issue("sll", 4'b1000, 3'b000, 32'd1, 32'd4, SLL_EXP, 1'b0, 1'b0, 1, 1'b1);

        issue("mul 2^16*2^16", 4'b0011, 3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 33, 1'b1);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready || out_valid) bad++;
            @(negedge clk);
        end
        chk("mul busy in_ready low", 64'(bad), 64'd0);

        @(negedge clk);
        out_ready = 1'b0;
        issue("backpressure add", 4'b0010, 3'b000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1, 1'b1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || result !== 32'd7 || in_ready) bad++;
            @(negedge clk);
        end
        chk("backpressure hold", 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("backpressure release in_ready", 64'(in_ready), 64'd1);
        chk("backpressure release out_valid", 64'(out_valid), 64'd0);
        issue("or after release", 4'b0001, 3'b000, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1, 1'b1);

        issue("mul aborted", 4'b0011, 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 33, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midmul reset out_valid", 64'(out_valid), 64'd0);
        chk("midmul reset result", 64'(result), 64'd0);
        chk("midmul reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue("mul 3*5", 4'b0011, 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 33, 1'b1);

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
